// File: rtl/mem_loader_pkg.sv
// Shared types for the boot-time frame loader.
// Parser states and frame field order.
package mem_loader_pkg;

  // Frame field order, in arrival order
  typedef enum logic [3:0] {
    S_IM_LEN_HI = 4'd0,
    S_IM_LEN_LO = 4'd1,
    S_IM_DATA   = 4'd2,
    S_DM_LEN_HI = 4'd3,
    S_DM_LEN_LO = 4'd4,
    S_DM_DATA   = 4'd5,
    S_CSUM      = 4'd6,
    S_DONE      = 4'd7,
    S_ERR       = 4'd8
  } ld_state_t;

  // Every state before DONE consumes stream bytes
  function automatic logic is_parse(ld_state_t s);
    return (s != S_DONE) && (s != S_ERR);
  endfunction

endpackage

// File: rtl/mem_loader.sv
// Boot loader: parses a framed byte stream into IM/DM
// writes, checks the checksum, then releases the processor.
// Ports: clk, rst_n (sync, active low), rx_data/rx_valid/
// rx_ready stream in, reload, mem_addr/mem_wdata/im_wr/
// dm_wr write port, proc_run, load_err.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int IM_DEPTH = 256,
  parameter int DM_DEPTH = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              im_wr,
  output logic              dm_wr,
  output logic              proc_run,
  output logic              load_err
);

  // One extra bit so a full 2^ADDR_W block cannot wrap
  localparam int CNT_W = ADDR_W + 1;

  ld_state_t         state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              im_wr_q, im_wr_d;
  logic              dm_wr_q, dm_wr_d;
  logic              run_q, run_d;
  logic              err_q, err_d;
  logic              rdy_q;

  logic              accept;
  logic [15:0]       len_new;
  logic              last;

  // rdy_q keeps rx_ready low through the reset cycle
  assign rx_ready = rdy_q & is_parse(state_q);
  assign accept   = rx_valid & rx_ready;
  assign len_new  = {len_hi_q, rx_data};
  assign last     = (32'(cnt_q) + 32'd1) == 32'(len_q);

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    im_wr_d  = 1'b0;
    dm_wr_d  = 1'b0;

    if (accept && state_q != S_CSUM)
      csum_d = csum_q + rx_data;

    unique case (state_q)
      S_IM_LEN_HI, S_DM_LEN_HI: begin
        if (accept) begin
          len_hi_d = rx_data;
          state_d  = (state_q == S_IM_LEN_HI)
                   ? S_IM_LEN_LO : S_DM_LEN_LO;
        end
      end
      S_IM_LEN_LO: begin
        if (accept) begin
          len_d = len_new;
          cnt_d = '0;
          if (32'(len_new) > 32'(IM_DEPTH))
            state_d = S_ERR;
          else if (len_new == 16'd0)
            state_d = S_DM_LEN_HI;
          else
            state_d = S_IM_DATA;
        end
      end
      S_DM_LEN_LO: begin
        if (accept) begin
          len_d = len_new;
          cnt_d = '0;
          if (32'(len_new) > 32'(DM_DEPTH))
            state_d = S_ERR;
          else if (len_new == 16'd0)
            state_d = S_CSUM;
          else
            state_d = S_DM_DATA;
        end
      end
      S_IM_DATA, S_DM_DATA: begin
        if (accept) begin
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = rx_data;
          cnt_d   = cnt_q + CNT_W'(1);
          if (state_q == S_IM_DATA) begin
            im_wr_d = 1'b1;
            if (last) state_d = S_DM_LEN_HI;
          end else begin
            dm_wr_d = 1'b1;
            if (last) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept)
          state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (reload) begin
          state_d = S_IM_LEN_HI;
          csum_d  = '0;
        end
      end
      default: state_d = S_IM_LEN_HI;
    endcase

    // Registered off DONE so the last dm_wr lands first
    run_d = (state_q == S_DONE) && !reload;
    err_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IM_LEN_HI;
      len_hi_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      csum_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      im_wr_q  <= 1'b0;
      dm_wr_q  <= 1'b0;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      im_wr_q  <= im_wr_d;
      dm_wr_q  <= dm_wr_d;
      run_q    <= run_d;
      err_q    <= err_d;
      rdy_q    <= 1'b1;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign im_wr     = im_wr_q;
  assign dm_wr     = dm_wr_q;
  assign proc_run  = run_q;
  assign load_err  = err_q;

endmodule
